// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions: operand-select codes, PC index and the
// per-stage destination tag carried through EX, MEM and WB.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  localparam logic [1:0] FWD_SEL_REG = 2'b00;
  localparam logic [1:0] FWD_SEL_MEM = 2'b01;
  localparam logic [1:0] FWD_SEL_WB  = 2'b10;

  localparam logic [REG_W-1:0] REG_PC = 4'hF;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
  } stage_tag_t;

  // A source depends on a stage when that stage will write the register
  // being read; the PC is never forwarded.
  function automatic logic tag_match(stage_tag_t tag, logic use_src,
                                     logic [REG_W-1:0] idx);
    return use_src && (idx != REG_PC) && tag.valid && tag.wb_en &&
           (tag.dest == idx);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_if.sv
// ID-side request and EX-side select bundle between decode and the
// forwarding/hazard unit.
interface forward_hazard_unit_if;
  import arm_pipe_pkg::*;

  logic             fwd_en;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_use_src1;
  logic             id_use_src2;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             stall;
  logic [1:0]       ex_sel_a;
  logic [1:0]       ex_sel_b;
  logic             ex_valid;

  modport master (
    output fwd_en, flush, id_valid, id_src1, id_src2, id_use_src1,
           id_use_src2, id_dest, id_wb_en, id_mem_read,
    input  stall, ex_sel_a, ex_sel_b, ex_valid
  );

  modport slave (
    input  fwd_en, flush, id_valid, id_src1, id_src2, id_use_src1,
           id_use_src2, id_dest, id_wb_en, id_mem_read,
    output stall, ex_sel_a, ex_sel_b, ex_valid
  );

endinterface

// File: rtl/hazard_compare.sv
// Per-source dependency check against the EX and MEM tags: yields the
// operand-select code and a stall request.
module hazard_compare
  import arm_pipe_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  logic             fwd_en_i,
  input  stage_tag_t       ex_tag_i,
  input  stage_tag_t       mem_tag_i,
  output logic [1:0]       sel_o,
  output logic             stall_o
);

  logic ex_hit;
  logic mem_hit;
  logic mem_rd_unused;

  assign ex_hit        = tag_match(ex_tag_i, use_i, src_i);
  assign mem_hit       = tag_match(mem_tag_i, use_i, src_i);
  // A load in MEM has its data by the time this source reaches EX.
  assign mem_rd_unused = mem_tag_i.mem_read;

  always_comb begin
    sel_o   = FWD_SEL_REG;
    stall_o = 1'b0;
    if (fwd_en_i) begin
      if (ex_hit) begin
        sel_o = FWD_SEL_MEM;
      end else if (mem_hit) begin
        sel_o = FWD_SEL_WB;
      end
      stall_o = ex_hit && ex_tag_i.mem_read;
    end else begin
      stall_o = ex_hit || mem_hit;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks in-flight destination tags through EX/MEM/WB, registers the EX
// operand-select codes and raises the ID stall for unresolved hazards.
module forward_hazard_unit
  import arm_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  forward_hazard_unit_if.slave  bus
);

  stage_tag_t ex_q, ex_d;
  stage_tag_t mem_q;
  stage_tag_t wb_q;
  logic [1:0] sel_a, sel_b;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;
  logic       stall_a, stall_b;
  logic       stall;
  logic       load_ex;
  logic       wb_tag_unused;

  hazard_compare u_cmp_a (
    .src_i     (bus.id_src1),
    .use_i     (bus.id_use_src1),
    .fwd_en_i  (bus.fwd_en),
    .ex_tag_i  (ex_q),
    .mem_tag_i (mem_q),
    .sel_o     (sel_a),
    .stall_o   (stall_a)
  );

  hazard_compare u_cmp_b (
    .src_i     (bus.id_src2),
    .use_i     (bus.id_use_src2),
    .fwd_en_i  (bus.fwd_en),
    .ex_tag_i  (ex_q),
    .mem_tag_i (mem_q),
    .sel_o     (sel_b),
    .stall_o   (stall_b)
  );

  // Flush outranks stall: the ID instruction is discarded, not held.
  always_comb begin
    stall   = (stall_a || stall_b) && bus.id_valid && !bus.flush;
    load_ex = bus.id_valid && !stall && !bus.flush;
    ex_d    = '0;
    sel_a_d = FWD_SEL_REG;
    sel_b_d = FWD_SEL_REG;
    if (load_ex) begin
      ex_d.valid    = 1'b1;
      ex_d.dest     = bus.id_dest;
      ex_d.wb_en    = bus.id_wb_en;
      ex_d.mem_read = bus.id_mem_read;
      sel_a_d       = sel_a;
      sel_b_d       = sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= FWD_SEL_REG;
      sel_b_q <= FWD_SEL_REG;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  // WB needs no forwarding: the register file is write-through.
  assign wb_tag_unused = ^wb_q;

  assign bus.stall    = stall;
  assign bus.ex_sel_a = sel_a_q;
  assign bus.ex_sel_b = sel_b_q;
  assign bus.ex_valid = ex_q.valid;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed vector table, mid-stall reset sequence and randomized run
// against an instruction-history reference model.
module tb_forward_hazard_unit;
  import arm_pipe_pkg::*;

  logic clk;
  logic rst_n;

  forward_hazard_unit_if bus();

  forward_hazard_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       fwd;
    bit       flush;
    bit       vld;
    int       s1;
    bit       u1;
    int       s2;
    bit       u2;
    int       dest;
    bit       wb;
    bit       ld;
    bit       e_stall;
    bit       e_valid;
    bit [1:0] e_sa;
    bit [1:0] e_sb;
  } vec_t;

  typedef struct {
    bit valid;
    int dest;
    bit wb;
    bit ld;
  } minstr_t;

  int n_total = 0;
  int n_pass  = 0;
  vec_t    vecs[$];
  minstr_t hist[$];   // hist[0] = instruction that entered EX most recently

  function automatic vec_t mk(bit fwd, bit flush, bit vld, int s1, bit u1,
                              int s2, bit u2, int dest, bit wb, bit ld,
                              bit es, bit ev, bit [1:0] sa, bit [1:0] sb);
    vec_t v;
    v.fwd = fwd; v.flush = flush; v.vld = vld;
    v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
    v.dest = dest; v.wb = wb; v.ld = ld;
    v.e_stall = es; v.e_valid = ev; v.e_sa = sa; v.e_sb = sb;
    return v;
  endfunction

  task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic drive(bit fwd, bit flush, bit vld, int s1, bit u1, int s2,
                       bit u2, int dest, bit wb, bit ld);
    bus.fwd_en      = fwd;
    bus.flush       = flush;
    bus.id_valid    = vld;
    bus.id_src1     = 4'(s1);
    bus.id_use_src1 = u1;
    bus.id_src2     = 4'(s2);
    bus.id_use_src2 = u2;
    bus.id_dest     = 4'(dest);
    bus.id_wb_en    = wb;
    bus.id_mem_read = ld;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic run_vec(vec_t v, int idx);
    drive(v.fwd, v.flush, v.vld, v.s1, v.u1, v.s2, v.u2, v.dest, v.wb, v.ld);
    #1;
    chk($sformatf("vec%0d stall", idx), {1'b0, bus.stall}, {1'b0, v.e_stall});
    @(posedge clk); #1;
    chk($sformatf("vec%0d ex_valid", idx), {1'b0, bus.ex_valid}, {1'b0, v.e_valid});
    chk($sformatf("vec%0d ex_sel_a", idx), bus.ex_sel_a, v.e_sa);
    chk($sformatf("vec%0d ex_sel_b", idx), bus.ex_sel_b, v.e_sb);
    @(negedge clk);
  endtask

  // How many instructions back the most recent writer of src sits
  // (1 = in EX, 2 = in MEM), 0 when no forwardable writer is in flight.
  function automatic int writer_age(int src, bit use_src);
    if (!use_src || src == 15) return 0;
    for (int a = 0; a < 2; a++) begin
      if (a < hist.size() && hist[a].valid && hist[a].wb && hist[a].dest == src)
        return a + 1;
    end
    return 0;
  endfunction

  function automatic bit [1:0] fwd_code(int age);
    if (age == 1) return 2'd1;
    if (age == 2) return 2'd2;
    return 2'd0;
  endfunction

  task automatic rand_step(int n, bit fwd);
    int       s1, s2, dest, a1, a2;
    bit       vld, flush, u1, u2, wb, ld, es, enters;
    bit [1:0] sa, sb;
    minstr_t  m;
    s1    = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    s2    = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    dest  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    vld   = ($urandom_range(0, 7) != 0);
    flush = ($urandom_range(0, 7) == 0);
    u1    = ($urandom_range(0, 3) != 0);
    u2    = ($urandom_range(0, 3) != 0);
    wb    = ($urandom_range(0, 3) != 0);
    ld    = ($urandom_range(0, 3) == 0);
    drive(fwd, flush, vld, s1, u1, s2, u2, dest, wb, ld);
    #1;
    a1 = writer_age(s1, u1);
    a2 = writer_age(s2, u2);
    if (!vld || flush)
      es = 1'b0;
    else if (fwd)
      es = (a1 == 1 || a2 == 1) && hist[0].ld;
    else
      es = (a1 != 0) || (a2 != 0);
    chk($sformatf("rnd%0d stall", n), {1'b0, bus.stall}, {1'b0, es});
    enters = vld && !es && !flush;
    sa = (enters && fwd) ? fwd_code(a1) : 2'd0;
    sb = (enters && fwd) ? fwd_code(a2) : 2'd0;
    m.valid = enters;
    m.dest  = enters ? dest : 0;
    m.wb    = enters && wb;
    m.ld    = enters && ld;
    hist.push_front(m);
    if (hist.size() > 3) void'(hist.pop_back());
    @(posedge clk); #1;
    chk($sformatf("rnd%0d ex_valid", n), {1'b0, bus.ex_valid}, {1'b0, enters});
    chk($sformatf("rnd%0d ex_sel_a", n), bus.ex_sel_a, sa);
    chk($sformatf("rnd%0d ex_sel_b", n), bus.ex_sel_b, sb);
    @(negedge clk);
  endtask

  initial begin
    bit fwd_r;
    // fwd flush vld  s1 u1 s2 u2 dest wb ld | stall valid sel_a sel_b
    vecs.push_back(mk(1,0,1,  2,1, 3,1,  1,1,0, 0,1,0,0));  // ADD R1
    vecs.push_back(mk(1,0,1,  1,1, 3,1,  2,1,0, 0,1,1,0));  // SUB R2 <- R1,R3
    vecs.push_back(mk(1,0,0,  0,0, 0,0,  0,0,0, 0,0,0,0));  // idle
    vecs.push_back(mk(1,0,1,  6,1, 7,1,  1,1,0, 0,1,0,0));  // ADD R1
    vecs.push_back(mk(1,0,1,  9,1,10,1,  8,1,0, 0,1,0,0));  // unrelated
    vecs.push_back(mk(1,0,1,  5,1, 1,1,  4,1,0, 0,1,0,2));  // ORR R4 <- R5,R1
    vecs.push_back(mk(1,0,1, 13,1, 0,0,  2,1,1, 0,1,0,0));  // LDR R2
    vecs.push_back(mk(1,0,1,  2,1, 2,1,  3,1,0, 1,0,0,0));  // ADD R3 <- R2,R2 stalls
    vecs.push_back(mk(1,0,1,  2,1, 2,1,  3,1,0, 0,1,2,2));  // held ADD enters
    vecs.push_back(mk(0,0,1,  5,1, 6,1,  1,1,0, 0,1,0,0));  // ADD R1, no forwarding
    vecs.push_back(mk(0,0,1,  1,1,15,1,  7,1,0, 1,0,0,0));  // SUB R7 <- R1,PC
    vecs.push_back(mk(0,0,1,  1,1,15,1,  7,1,0, 1,0,0,0));
    vecs.push_back(mk(0,0,1,  1,1,15,1,  7,1,0, 0,1,0,0));
    vecs.push_back(mk(0,0,1,  8,1, 9,1, 15,1,0, 0,1,0,0));  // writes PC
    vecs.push_back(mk(1,0,1, 15,1, 7,0,  0,0,0, 0,1,0,0));  // reads PC, unused R7
    vecs.push_back(mk(1,0,1, 10,1,11,1,  9,1,1, 0,1,0,0));  // LDR R9
    vecs.push_back(mk(1,1,1,  9,1, 9,1,  2,1,0, 0,0,0,0));  // load-use with flush
    vecs.push_back(mk(1,0,1,  9,1, 9,1,  2,1,0, 0,1,2,2));
    vecs.push_back(mk(1,0,0,  2,1, 2,1,  0,0,0, 0,0,0,0));  // invalid ID never stalls
    vecs.push_back(mk(0,0,1,  3,1, 0,0,  3,1,0, 0,1,0,0));  // ADD R3
    vecs.push_back(mk(0,0,1,  0,0, 0,0,  5,1,0, 0,1,0,0));  // unrelated
    vecs.push_back(mk(0,0,1,  4,0, 3,1,  6,1,0, 1,0,0,0));  // two-back: one stall
    vecs.push_back(mk(0,0,1,  4,0, 3,1,  6,1,0, 0,1,0,0));
    vecs.push_back(mk(1,0,1,  0,0, 0,0,  4,1,0, 0,1,0,0));  // ADD R4
    vecs.push_back(mk(1,0,1,  4,1, 0,0,  5,1,1, 0,1,1,0));  // LDR R5 <- R4

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset stall",    {1'b0, bus.stall},    2'd0);
    chk("reset ex_valid", {1'b0, bus.ex_valid}, 2'd0);
    chk("reset ex_sel_a", bus.ex_sel_a, 2'd0);
    chk("reset ex_sel_b", bus.ex_sel_b, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Load-use stall in progress, then asynchronous reset mid-cycle.
    drive(1, 0, 1, 5, 1, 5, 1, 6, 1, 0);
    #1;
    chk("midrst stall before",    {1'b0, bus.stall},    2'd1);
    chk("midrst ex_valid before", {1'b0, bus.ex_valid}, 2'd1);
    chk("midrst ex_sel_a before", bus.ex_sel_a, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst stall",    {1'b0, bus.stall},    2'd0);
    chk("midrst ex_valid", {1'b0, bus.ex_valid}, 2'd0);
    chk("midrst ex_sel_a", bus.ex_sel_a, 2'd0);
    chk("midrst ex_sel_b", bus.ex_sel_b, 2'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();

    fwd_r = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 249) fwd_r = ~fwd_r;
      rand_step(n, fwd_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
